store_narrow: RTL and testbench

- Store-side data path: the inverse of the immediate/load extender. Takes a 32-bit register value plus byte address and narrows it to word, halfword or byte.
- Lane-replicates the narrowed data and generates byte enables for the data memory.
- Single registered pipeline stage with valid/ready handshake, between the MEM-stage store logic and the DM write port.
- Flags misaligned or illegal stores and, optionally, lossy narrowing.

---
 rtl/store_narrow.sv | 121 ++++++++++++
 tb/tb_store_narrow.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/store_narrow.sv
// Store-side narrowing stage: word/half/byte lane replication, byte enables and
// address/size exception checks. Optional lossy-narrowing flag under STORE_NARROW_LOSSY_EN.
module store_narrow #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_data,
    input  logic [1:0]        SOp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              exc_ades,
    output logic              lossy,
    output logic [CNT_W-1:0]  store_cnt
);

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    logic        accept;
    logic        exc_n;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [1:0]  a;

    assign a        = in_addr[1:0];
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Excepting stores leave be/wdata at zero so memory is never written.
    always_comb begin
        exc_n   = 1'b0;
        be_n    = '0;
        wdata_n = '0;
        case (size_e'(SOp))
            SZ_WORD: begin
                if (a != 2'b00) begin
                    exc_n = 1'b1;
                end else begin
                    be_n    = 4'b1111;
                    wdata_n = in_data;
                end
            end
            SZ_HALF: begin
                if (a[0]) begin
                    exc_n = 1'b1;
                end else begin
                    be_n    = a[1] ? 4'b1100 : 4'b0011;
                    wdata_n = {2{in_data[15:0]}};
                end
            end
            SZ_BYTE: begin
                be_n    = 4'b0001 << a;
                wdata_n = {4{in_data[7:0]}};
            end
            default: exc_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            exc_ades  <= 1'b0;
            store_cnt <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            mem_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= wdata_n;
            mem_be    <= be_n;
            exc_ades  <= exc_n;
            if (!exc_n) begin
                store_cnt <= store_cnt + CNT_W'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef STORE_NARROW_LOSSY_EN
    logic lossy_n;

    // Lossy when the discarded upper bits are neither zero- nor sign-extension.
    always_comb begin
        lossy_n = 1'b0;
        if (!exc_n) begin
            if (SOp == SZ_HALF) begin
                lossy_n = !((in_data[31:16] == '0) ||
                            (in_data[31:16] == {16{in_data[15]}}));
            end else if (SOp == SZ_BYTE) begin
                lossy_n = !((in_data[31:8] == '0) ||
                            (in_data[31:8] == {24{in_data[7]}}));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lossy <= 1'b0;
        end else if (accept) begin
            lossy <= lossy_n;
        end
    end
`else
    assign lossy = 1'b0;
`endif

endmodule

// File: tb/tb_store_narrow.sv
// Scoreboard bench for store_narrow: directed stores push expected responses,
// a negedge monitor pops and compares on each output handshake.
module tb_store_narrow;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_addr = '0;
    logic [31:0] in_data = '0;
    logic [1:0]  SOp = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        exc_ades;
    logic        lossy;
    logic [15:0] store_cnt;

    store_narrow #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .SOp(SOp),
        .out_valid(out_valid), .out_ready(out_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .exc_ades(exc_ades),
        .lossy(lossy), .store_cnt(store_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        exc;
        logic        lossy;
        logic [15:0] cnt;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] cnt_m = '0;
    bit          mon_en = 1'b1;

    function automatic logic lossy_exp(input logic v);
`ifdef STORE_NARROW_LOSSY_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got addr %h want none", mem_addr);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("mem_addr", mem_addr, e.addr);
                check("mem_wdata", mem_wdata, e.wdata);
                check("mem_be", {28'd0, mem_be}, {28'd0, e.be});
                check("exc_ades", {31'd0, exc_ades}, {31'd0, e.exc});
                check("lossy", {31'd0, lossy}, {31'd0, e.lossy});
                check("store_cnt", {16'd0, store_cnt}, {16'd0, e.cnt});
            end
        end
    end

    // Drives one request (leaves in_valid high) and returns #1 after the accepting edge.
    task automatic issue(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sop,
                         input logic [31:0] e_addr, input logic [31:0] e_wdata,
                         input logic [3:0] e_be, input logic e_exc, input logic e_lossy);
        int n;
        exp_t e;
        in_addr  = addr;
        in_data  = data;
        SOp      = sop;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: got in_ready 0 want 1");
        end else begin
            if (!e_exc) cnt_m = cnt_m + 16'd1;
            e.addr  = e_addr;
            e.wdata = e_wdata;
            e.be    = e_be;
            e.exc   = e_exc;
            e.lossy = lossy_exp(e_lossy);
            e.cnt   = cnt_m;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check("rst_store_cnt", {16'd0, store_cnt}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_exc_lossy", {30'd0, exc_ades, lossy}, 32'd0);

        @(posedge clk);
        #1 out_ready = 1'b1;
        issue(32'h13,  32'h123456AB, 2'b10, 32'h10,  32'hABABABAB, 4'b1000, 1'b0, 1'b1);
        issue(32'h22,  32'h0000BEEF, 2'b01, 32'h20,  32'hBEEFBEEF, 4'b1100, 1'b0, 1'b0);
        issue(32'h21,  32'hDEADBEEF, 2'b00, 32'h20,  32'h00000000, 4'b0000, 1'b1, 1'b0);
        issue(32'h104, 32'hCAFEF00D, 2'b00, 32'h104, 32'hCAFEF00D, 4'b1111, 1'b0, 1'b0);
        issue(32'h51,  32'h00001234, 2'b01, 32'h50,  32'h00000000, 4'b0000, 1'b1, 1'b0);
        issue(32'h60,  32'hFFFF8001, 2'b01, 32'h60,  32'h80018001, 4'b0011, 1'b0, 1'b0);
        issue(32'h00,  32'h000000FF, 2'b10, 32'h00,  32'hFFFFFFFF, 4'b0001, 1'b0, 1'b0);
        issue(32'h0E,  32'h00000042, 2'b10, 32'h0C,  32'h42424242, 4'b0100, 1'b0, 1'b0);
        issue(32'h40,  32'hFFFFFF80, 2'b10, 32'h40,  32'h80808080, 4'b0001, 1'b0, 1'b0);
        issue(32'h42,  32'h00012345, 2'b01, 32'h40,  32'h23452345, 4'b1100, 1'b0, 1'b1);
        issue(32'h40,  32'h12345678, 2'b11, 32'h40,  32'h00000000, 4'b0000, 1'b1, 1'b0);

        // Back-pressure: hold A, offer B, then release and replace in one cycle.
        issue(32'h30,  32'h11223344, 2'b00, 32'h30,  32'h11223344, 4'b1111, 1'b0, 1'b0);
        out_ready = 1'b0;
        in_addr   = 32'h34;
        in_data   = 32'h55667788;
        SOp       = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_mem_addr", mem_addr, 32'h30);
            check("bp_mem_wdata", mem_wdata, 32'h11223344);
            check("bp_mem_be", {28'd0, mem_be}, 32'hF);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        issue(32'h34,  32'h55667788, 2'b10, 32'h34,  32'h88888888, 4'b0001, 1'b0, 1'b1);
        check("repl_out_valid", {31'd0, out_valid}, 32'd1);
        check("repl_mem_wdata", mem_wdata, 32'h88888888);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("drain_queue_empty", q.size(), 32'd0);

        // Counter wrap: reset, 65535 unchecked word stores, then one checked store.
        mon_en = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        in_addr  = 32'h200;
        in_data  = 32'h01020304;
        SOp      = 2'b00;
        in_valid = 1'b1;
        repeat (65535) @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        check("preload_cnt", {16'd0, store_cnt}, 32'h0000FFFF);
        check("preload_idle", {31'd0, out_valid}, 32'd0);
        cnt_m = 16'hFFFF;
        @(posedge clk);
        #1;
        issue(32'h204, 32'h0BADF00D, 2'b00, 32'h204, 32'h0BADF00D, 4'b1111, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("wrap_cnt", {16'd0, store_cnt}, 32'd0);

        // Reset while a request is held under back-pressure drops it.
        @(posedge clk);
        #1 out_ready = 1'b0;
        in_addr  = 32'h88;
        in_data  = 32'hA5A5A5A5;
        SOp      = 2'b00;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("held_out_valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_mem_be", {28'd0, mem_be}, 32'd0);
        check("mid_rst_mem_addr", mem_addr, 32'd0);
        check("mid_rst_store_cnt", {16'd0, store_cnt}, 32'd0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("dropped_stays_idle", {31'd0, out_valid}, 32'd0);
        check("final_queue_empty", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
